// File: rtl/booth_step_engine_if.sv
// Operand/product handshake bundle for the Booth step engine.
// master drives operands and out_ready, slave (the engine) answers.
interface booth_step_engine_if #(
    parameter int unsigned WIDTH_IN = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH_IN-1:0]     in_a;
    logic [WIDTH_IN-1:0]     in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*WIDTH_IN-1:0]   product;
    logic                    busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_step_engine.sv
// Sequential radix-2 Booth multiplier core working on the {A, Q, Q-1} layout.
// One add/subtract + arithmetic shift per cycle; WIDTH_IN steps per product.
module booth_step_engine #(
    parameter int unsigned WIDTH_IN = 16,
    parameter int unsigned WIDTH_PP = 33,
    parameter int unsigned CNT_W    = 5
) (
    input logic                clk,
    input logic                reset,
    input logic                clear,
    booth_step_engine_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH_IN - 1);

    state_t              state_q, state_d;
    // A carries one guard bit so that M = -2^(WIDTH_IN-1) subtracts exactly
    logic [WIDTH_IN:0]   a_q, a_d;
    logic [WIDTH_IN-1:0] q_q, q_d;
    logic                q1_q, q1_d;
    logic [WIDTH_IN-1:0] m_q, m_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [WIDTH_IN:0]   m_ext;
    logic [WIDTH_IN:0]   s;
    logic [WIDTH_PP:0]   pp_sum;
    logic [WIDTH_PP:0]   pp_shift;

    // One Booth step: select add/sub/none on {Q[0], Q-1}, then shift right arithmetically
    always_comb begin
        m_ext = {m_q[WIDTH_IN-1], m_q};
        s     = a_q;
        unique case ({q_q[0], q1_q})
            2'b01:   s = a_q + m_ext;
            2'b10:   s = a_q - m_ext;
            default: s = a_q;
        endcase
        pp_sum   = {s, q_q, q1_q};
        pp_shift = {pp_sum[WIDTH_PP], pp_sum[WIDTH_PP:1]};
    end

    // Next-state and datapath update; clear overrides everything else
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = '0;
                    q_d     = bus.in_b;
                    q1_d    = 1'b0;
                    m_d     = bus.in_a;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = pp_shift[WIDTH_PP -: (WIDTH_IN + 1)];
                q_d   = pp_shift[WIDTH_IN:1];
                q1_d  = pp_shift[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            state_d = StIdle;
            a_d     = '0;
            q_d     = '0;
            q1_d    = 1'b0;
            m_d     = '0;
            cnt_d   = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StRun) || (state_q == StDone);
    // Guard bit dropped: the product always fits in 2*WIDTH_IN bits
    assign bus.product   = {a_q[WIDTH_IN-1:0], q_q};

endmodule

// File: tb/tb_booth_step_engine.sv
// Directed and random checks for booth_step_engine.
module tb_booth_step_engine;

    logic clk;
    logic reset;
    logic clear;
    int   checks;
    int   errors;

    booth_step_engine_if #(.WIDTH_IN(16)) bus ();

    booth_step_engine #(
        .WIDTH_IN(16),
        .WIDTH_PP(33),
        .CNT_W   (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operand pair, wait for the product, optionally stall, then take it.
    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp, input int stall, input bit early,
                           input bit poke);
        int lat;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        bus.out_ready = early;
        step();
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (poke) begin
                bus.in_valid = lat[0];
                bus.in_a     = 16'($urandom);
            end
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd16);
        check({tag, "_product"}, 64'(bus.product), 64'(exp));
        if (!early) begin
            for (int i = 0; i < stall; i++) begin
                if (poke) bus.in_valid = ~bus.in_valid;
                step();
                check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
                check({tag, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
                check({tag, "_hold_product"}, 64'(bus.product), 64'(exp));
            end
            bus.out_ready = 1'b1;
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_post_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_post_product"}, 64'(bus.product), 64'(exp));
    endtask

    initial begin
        logic signed [15:0] ra;
        logic signed [15:0] rb;
        logic signed [31:0] rp;
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_product", 64'(bus.product), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_product", 64'(bus.product), 64'd0);

        // Basic and sign cases
        run_mul("basic", 16'd3, 16'd5, 32'h0000000F, 0, 1'b1, 1'b0);
        run_mul("neg1sq", 16'hFFFF, 16'hFFFF, 32'h00000001, 0, 1'b1, 1'b0);
        run_mul("max_min", 16'h7FFF, 16'h8000, 32'hC0008000, 1, 1'b0, 1'b0);
        run_mul("min_min", 16'h8000, 16'h8000, 32'h40000000, 0, 1'b0, 1'b0);
        run_mul("zero", 16'h0000, 16'h1234, 32'h00000000, 0, 1'b1, 1'b0);

        // Backpressure with ignored in_valid pulses
        run_mul("bp", 16'hFFF9, 16'd6, 32'hFFFFFFD6, 10, 1'b0, 1'b1);

        // clear during run
        bus.in_a = 16'd100;
        bus.in_b = 16'd200;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("clr_busy_before", 64'(bus.busy), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_in_ready", 64'(bus.in_ready), 64'd1);
        check("clr_out_valid", 64'(bus.out_valid), 64'd0);
        check("clr_busy", 64'(bus.busy), 64'd0);
        check("clr_product", 64'(bus.product), 64'd0);

        // asynchronous reset during run
        bus.in_a = 16'd321;
        bus.in_b = 16'd123;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b0;
        #1;
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_product", 64'(bus.product), 64'd0);
        step();
        reset = 1'b1;
        step();
        run_mul("after_abort", 16'd12, 16'd12, 32'h00000090, 0, 1'b1, 1'b0);

        // Random operands with random stalls
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rp = ra * rb;
            run_mul("rand", ra, rb, rp, int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
